queue_drain_ctrl: RTL and testbench

//   Consumer-side controller for the load/shift queue (write buffer). Tracks queue occupancy from the

---
 rtl/queue_drain_ctrl_if.sv | 27 ++
 rtl/queue_drain_ctrl.sv | 148 ++++++++++++++
 tb/tb_queue_drain_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/queue_drain_ctrl_if.sv
// Interface between the queue-drain controller, the load/shift queue and the
// data-memory write port.
// master: the drain controller. slave: the queue producer/consumer side plus memory.
interface queue_drain_ctrl_if #(
  parameter int width = 32
);
  logic             q_load;
  logic [width-1:0] q_out;
  logic             q_shift;
  logic             hold;
  logic             mem_write;
  logic [width-1:0] mem_wdata;
  logic             mem_resp;
  logic             q_full;
  logic             drained;
  logic             drain_err;

  modport master (
    input  q_load, q_out, hold, mem_resp,
    output q_shift, mem_write, mem_wdata, q_full, drained, drain_err
  );

  modport slave (
    output q_load, q_out, hold, mem_resp,
    input  q_shift, mem_write, mem_wdata, q_full, drained, drain_err
  );
endinterface

// File: rtl/queue_drain_ctrl.sv
// Consumer-side controller for the load/shift write-buffer queue.
// Tracks occupancy from producer load strobes, pops the head entry with a
// one-cycle shift pulse, captures the popped word and writes it to memory over
// a req/resp handshake, one entry in flight at a time. drained signals that all
// buffered stores have completed (used by fences).
// Optional feature: define DRAIN_TIMEOUT_EN to add a response timeout that
// discards the stuck entry and sets the sticky drain_err flag.
module queue_drain_ctrl #(
  parameter int width   = 32,
  parameter int entries = 4
`ifdef DRAIN_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic                clk,
  input  logic                rst,
  queue_drain_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    REQ  = 2'd3
  } state_e;

  // Queue depth; the occupancy counter saturates at this value.
  localparam logic [entries:0] size = {1'b1, {entries{1'b0}}};

`ifdef DRAIN_TIMEOUT_EN
  localparam int tmo_w = $clog2(TIMEOUT + 1);
  // Value of the wait counter during the last REQ cycle before giving up.
  localparam logic [tmo_w-1:0] tmo_last = tmo_w'(TIMEOUT - 1);
`endif

  state_e           state_q,     state_d;
  logic [entries:0] count_q,     count_d;
  logic             q_shift_q,   q_shift_d;
  logic             mem_write_q, mem_write_d;
  logic [width-1:0] mem_wdata_q, mem_wdata_d;
`ifdef DRAIN_TIMEOUT_EN
  logic             drain_err_q, drain_err_d;
  logic [tmo_w-1:0] wait_cnt_q,  wait_cnt_d;
`endif

  // Occupancy: +1 per load, -1 per pop, unchanged when both coincide; a load
  // into a full queue is a producer error and is dropped.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    count_d = count_q;
    unique case ({bus.q_load, q_shift_q})
      2'b10:   if (count_q != size) count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Next-state and registered-output logic for the pop/capture/request FSM.
  always_comb begin
    state_d     = state_q;
    q_shift_d   = 1'b0;
    mem_write_d = mem_write_q;
    mem_wdata_d = mem_wdata_q;
`ifdef DRAIN_TIMEOUT_EN
    drain_err_d = drain_err_q;
    wait_cnt_d  = wait_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // hold only gates the start of a new pop; a transfer already under
        // way always runs to completion.
        if ((count_q != '0) && !bus.hold) begin
          state_d   = POP;
          q_shift_d = 1'b1;
        end
      end
      POP: begin
        // The queue presents the popped head during the following cycle.
        state_d = CAPT;
      end
      CAPT: begin
        mem_wdata_d = bus.q_out;
        mem_write_d = 1'b1;
        state_d     = REQ;
`ifdef DRAIN_TIMEOUT_EN
        wait_cnt_d  = '0;
`endif
      end
      REQ: begin
        if (bus.mem_resp) begin
          mem_write_d = 1'b0;
          state_d     = IDLE;
`ifdef DRAIN_TIMEOUT_EN
        end else if (wait_cnt_q == tmo_last) begin
          // Give up on this entry; it is discarded and draining moves on.
          mem_write_d = 1'b0;
          drain_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d  = wait_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight entry.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      q_shift_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
`ifdef DRAIN_TIMEOUT_EN
      drain_err_q <= 1'b0;
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      q_shift_q   <= q_shift_d;
      mem_write_q <= mem_write_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef DRAIN_TIMEOUT_EN
      drain_err_q <= drain_err_d;
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign bus.q_shift   = q_shift_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.q_full    = (count_q == size);
  assign bus.drained   = (count_q == '0) && (state_q == IDLE);
`ifdef DRAIN_TIMEOUT_EN
  assign bus.drain_err = drain_err_q;
`else
  assign bus.drain_err = 1'b0;
`endif

endmodule

// File: tb/tb_queue_drain_ctrl.sv
// Directed bench for queue_drain_ctrl. A small behavioural queue supplies
// q_out, a monitor records completed memory writes and pop pulses, and the
// stimulus is one linear sequence of directed steps. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_queue_drain_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  queue_drain_ctrl_if #(.width(32)) bus ();

  queue_drain_ctrl #(
    .width(32),
    .entries(4)
`ifdef DRAIN_TIMEOUT_EN
    ,
    .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        auto_resp   = 1'b0;
  logic        resp_manual = 1'b0;
  logic [31:0] load_data   = '0;
  logic [31:0] fifo[$];
  logic [31:0] writes[$];
  int          shift_cnt   = 0;

  assign bus.mem_resp = auto_resp ? bus.mem_write : resp_manual;

  // Behavioural 16-deep queue: head appears on q_out the cycle after a pop.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo.delete();
      bus.q_out <= '0;
    end else begin
      if (bus.q_shift && fifo.size() > 0) bus.q_out <= fifo.pop_front();
      if (bus.q_load && fifo.size() < 16) fifo.push_back(load_data);
    end
  end

  // Monitor: count pop pulses and record accepted memory writes.
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.q_shift) shift_cnt <= shift_cnt + 1;
      if (bus.mem_write && bus.mem_resp) writes.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_drained(input int budget, input string tag);
    int n = 0;
    while (bus.drained !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, {63'd0, bus.drained}, 64'd1);
  endtask

  task automatic wait_mem_write(input int budget, input string tag);
    int n = 0;
    while (bus.mem_write !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, {63'd0, bus.mem_write}, 64'd1);
  endtask

  initial begin
    int wbase;
    int sbase;
    int hi;

    bus.q_load = 1'b0;
    bus.hold   = 1'b0;

    // ---- reset state ----
    tick();
    check("rst_q_shift",   {63'd0, bus.q_shift},   64'd0);
    check("rst_mem_write", {63'd0, bus.mem_write}, 64'd0);
    check("rst_wdata",     {32'd0, bus.mem_wdata}, 64'd0);
    check("rst_q_full",    {63'd0, bus.q_full},    64'd0);
    check("rst_drained",   {63'd0, bus.drained},   64'd1);
    check("rst_drain_err", {63'd0, bus.drain_err}, 64'd0);
    rst = 1'b0;

    // ---- reset mid-REQ with count=3 ----
    for (int i = 0; i < 4; i++) begin
      bus.q_load = 1'b1;
      load_data  = 32'h1111_0000 + i;
      tick();
    end
    bus.q_load = 1'b0;
    check("midreq_mem_write", {63'd0, bus.mem_write}, 64'd1);
    check("midreq_count",     64'(dut.count_q),       64'd3);
    #1 rst = 1'b1;
    #1;
    check("arst_mem_write", {63'd0, bus.mem_write}, 64'd0);
    check("arst_q_shift",   {63'd0, bus.q_shift},   64'd0);
    check("arst_drained",   {63'd0, bus.drained},   64'd1);
    check("arst_count",     64'(dut.count_q),       64'd0);
    tick();
    rst = 1'b0;
    tick();

    // ---- single entry, response after 2 REQ cycles ----
    wbase = writes.size();
    bus.q_load = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    tick();
    bus.q_load = 1'b0;
    check("one_count",      64'(dut.count_q),       64'd1);
    check("one_drained0",   {63'd0, bus.drained},   64'd0);
    tick();
    check("one_shift_hi",   {63'd0, bus.q_shift},   64'd1);
    tick();
    check("one_shift_lo",   {63'd0, bus.q_shift},   64'd0);
    check("one_capt_nowr",  {63'd0, bus.mem_write}, 64'd0);
    tick();
    check("one_req1_write", {63'd0, bus.mem_write}, 64'd1);
    check("one_wdata",      {32'd0, bus.mem_wdata}, 64'hDEAD_BEEF);
    tick();
    check("one_req2_write", {63'd0, bus.mem_write}, 64'd1);
    resp_manual = 1'b1;
    tick();
    resp_manual = 1'b0;
    check("one_write_done", {63'd0, bus.mem_write}, 64'd0);
    check("one_drained1",   {63'd0, bus.drained},   64'd1);
    check("one_nwrites",    64'(writes.size() - wbase), 64'd1);

    // ---- fill to 16 under hold, extra load ignored, then drain ----
    wbase = writes.size();
    sbase = shift_cnt;
    bus.hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.q_load = 1'b1;
      load_data  = (i < 16) ? 32'h3000_0000 + i : 32'hBAD0_0017;
      tick();
    end
    bus.q_load = 1'b0;
    check("fill_count",   64'(dut.count_q),           64'd16);
    check("fill_q_full",  {63'd0, bus.q_full},        64'd1);
    check("fill_noshift", 64'(shift_cnt - sbase),     64'd0);
    auto_resp = 1'b1;
    bus.hold  = 1'b0;
    wait_drained(200, "fill_drained");
    repeat (5) tick();
    check("fill_nwrites", 64'(writes.size() - wbase), 64'd16);
    check("fill_nshifts", 64'(shift_cnt - sbase),     64'd16);
    check("fill_q_full0", {63'd0, bus.q_full},        64'd0);
    for (int i = 0; i < 16 && (wbase + i) < writes.size(); i++)
      check($sformatf("fill_order%0d", i), {32'd0, writes[wbase+i]}, 64'(32'h3000_0000 + i));

    // ---- hold with count=2, simultaneous load/pop at 5, hold raised in REQ ----
    auto_resp = 1'b0;
    wbase = writes.size();
    sbase = shift_cnt;
    bus.hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.q_load = 1'b1;
      load_data  = 32'h5000_0000 + i;
      tick();
    end
    bus.q_load = 1'b0;
    repeat (3) tick();
    check("hold_count2",  64'(dut.count_q),       64'd2);
    check("hold_noshift", 64'(shift_cnt - sbase), 64'd0);
    for (int i = 2; i < 5; i++) begin
      bus.q_load = 1'b1;
      load_data  = 32'h5000_0000 + i;
      tick();
    end
    bus.q_load = 1'b0;
    bus.hold   = 1'b0;
    tick();
    check("hold_resume",   {63'd0, bus.q_shift}, 64'd1);
    check("both_pre",      64'(dut.count_q),     64'd5);
    bus.q_load = 1'b1;
    load_data  = 32'h5000_0005;
    tick();
    bus.q_load = 1'b0;
    bus.hold   = 1'b1;
    check("both_count5",   64'(dut.count_q),     64'd5);
    tick();
    check("hreq_write",    {63'd0, bus.mem_write}, 64'd1);
    check("hreq_wdata",    {32'd0, bus.mem_wdata}, 64'h5000_0000);
    resp_manual = 1'b1;
    tick();
    resp_manual = 1'b0;
    check("hreq_done",     {63'd0, bus.mem_write}, 64'd0);
    check("hreq_nwrites",  64'(writes.size() - wbase), 64'd1);
    repeat (3) tick();
    check("hreq_held",     64'(shift_cnt - sbase), 64'd1);
    auto_resp = 1'b1;
    bus.hold  = 1'b0;
    wait_drained(100, "hold_drained");
    check("hold_nwrites",  64'(writes.size() - wbase), 64'd6);
    for (int i = 0; i < 6 && (wbase + i) < writes.size(); i++)
      check($sformatf("hold_order%0d", i), {32'd0, writes[wbase+i]}, 64'(32'h5000_0000 + i));
    check("no_drain_err",  {63'd0, bus.drain_err}, 64'd0);

`ifdef DRAIN_TIMEOUT_EN
    // ---- response timeout: first entry discarded, second drains ----
    auto_resp = 1'b0;
    wbase = writes.size();
    bus.hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.q_load = 1'b1;
      load_data  = 32'h6000_000A + i;
      tick();
    end
    bus.q_load = 1'b0;
    bus.hold   = 1'b0;
    wait_mem_write(20, "tmo_req_start");
    hi = 0;
    while (bus.mem_write === 1'b1 && hi < 50) begin
      hi++;
      tick();
    end
    check("tmo_req_cycles", 64'(hi), 64'd8);
    check("tmo_err_set",    {63'd0, bus.drain_err}, 64'd1);
    check("tmo_no_write",   64'(writes.size() - wbase), 64'd0);
    wait_mem_write(20, "tmo_next_req");
    check("tmo_next_wdata", {32'd0, bus.mem_wdata}, 64'h6000_000B);
    resp_manual = 1'b1;
    tick();
    resp_manual = 1'b0;
    check("tmo_err_sticky", {63'd0, bus.drain_err}, 64'd1);
    check("tmo_drained",    {63'd0, bus.drained},   64'd1);
    check("tmo_nwrites",    64'(writes.size() - wbase), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
